taylor_horner_eval: RTL and testbench
=====================================

TAYLOR_HORNER_EVAL -- requirements
Module: taylor_horner_eval

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed fixed-point operand/result width.
REQ-002 SHALL have parameter FRAC_BITS, default 16: fractional bits of every operand (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
REQ-003 SHALL have parameter ADDR_LINES, default 5: coefficient table depth 2**ADDR_LINES.
REQ-004 SHALL have port clk_i  in  1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rstn_i  in  1: reset, synchronous, active-low.
REQ-006 SHALL have ports coeff_we  in  1; coeff_addr  in  ADDR_LINES; coeff_wdata  in  DATA_WIDTH: coefficient c[k] write port.
REQ-007 SHALL have port coeff_ready  out  1: coefficient writes are accepted this cycle.
REQ-008 SHALL have ports in_valid  in  1; in_ready  out  1; x_i  in  DATA_WIDTH; taylor_length  in  ADDR_LINES (highest term index N); mode_i  in  2 (0=ALL, 1=EVEN, 2=ODD, 3=reserved treated as ALL).
REQ-009 SHALL have ports out_valid  out  1; out_ready  in  1; result  out  DATA_WIDTH; sat_o  out  1 (a saturation occurred during this result).

Function
REQ-010 SHALL evaluate by Horner: ALL: sum c[k]*x^k, k=0..N; EVEN: sum c[k]*x^(2k); ODD: x * sum c[k]*x^(2k).
REQ-011 SHALL implement states IDLE, PREP, ITER, POST, DONE.
REQ-012 IDLE: in_ready=1, coeff_ready=1; on in_valid&&in_ready latch x_i, taylor_length, mode_i, clear sat flag, go PREP.
REQ-013 PREP (1 cycle): x_eff = x (ALL) or sat(x*x) (EVEN/ODD); acc = c[N]; k = N; go ITER if N>0, else POST if ODD, else DONE.
REQ-014 ITER: each cycle acc = sat(sat(acc*x_eff) + c[k-1]), k decrements; when k reaches 0 go POST if ODD, else DONE.
REQ-015 POST (1 cycle): acc = sat(acc*x); go DONE.
REQ-016 DONE: out_valid=1, result=acc, sat_o=sticky flag; held stable until out_ready; on out_valid&&out_ready go IDLE (out_valid low next cycle).
REQ-017 Latency accept->out_valid SHALL be N+2 cycles (ALL/EVEN), N+3 (ODD); no new input accepted before the handshake of the previous result.
REQ-018 Multiply SHALL form full 2*DATA_WIDTH signed product, arithmetic shift right FRAC_BITS (truncate toward -inf), saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-019 Add SHALL saturate to the same range; any clamp in multiply or add sets the sticky sat flag.
REQ-020 Coefficient write SHALL take effect only when coeff_we&&coeff_ready; writes while busy are dropped.
REQ-021 Coefficient read SHALL be combinational from the register array.
REQ-022 in_valid while not IDLE SHALL be ignored (in_ready=0); mode/length changes while busy have no effect.

Reset
REQ-023 rstn_i low at a clock edge SHALL force state IDLE, acc=0, k=0, sat flag=0, out_valid=0, result=0, sat_o=0, in_ready=1, coeff_ready=1 from the next cycle, including mid-ITER/DONE.
REQ-024 Coefficient array SHALL NOT be reset; contents survive reset.

Structure
REQ-025 Mode enum, state enum and default parameter constants SHALL live in shared package nla_pkg.
REQ-026 Saturating fixed-point multiply SHALL be sub-module fxp_mul_sat (instantiated once, shared by PREP/ITER/POST via operand mux).

Verification (Q16.16, 1.0=0x00010000)
REQ-027 c0=1.0,c1=1.0,c2=0.5(0x00008000), N=2, ALL, x=1.0 -> result 0x00028000, out_valid 4 cycles after accept, sat_o=0.
REQ-028 c0=1.0,c1=1.0, N=1, ODD, x=2.0 -> result 0x000A0000 at N+3=4 cycles; EVEN same setup -> 0x00050000 at 3 cycles.
REQ-029 c0=0x7FFF0000,c1=1.0, N=1, ALL, x=2.0 -> result 0x7FFFFFFF, sat_o=1; negative mirror (c0=0x80010000,x=-2.0) -> 0x80000000, sat_o=1.
REQ-030 out_ready low 5 cycles in DONE -> result/out_valid stable, in_ready=0, coeff write dropped (readback via N=0 shows old value).
REQ-031 rstn_i low mid-ITER -> next cycle out_valid=0, result=0, in_ready=1; subsequent N=0 run returns pre-reset c[0].

Source files
------------

// File: rtl/nla_pkg.sv
// Shared types and defaults for the fixed-point Horner polynomial evaluator.
package nla_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_FRAC_BITS  = 16;
   localparam int unsigned DEF_ADDR_LINES = 5;

   typedef enum logic [1:0] {
      MODE_ALL  = 2'd0,
      MODE_EVEN = 2'd1,
      MODE_ODD  = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_e;

   // EVEN and ODD both iterate in x^2; the reserved encoding behaves as ALL.
   function automatic logic mode_uses_square(input mode_e m);
      return (m == MODE_EVEN) || (m == MODE_ODD);
   endfunction

   // Only ODD needs the final multiply by x.
   function automatic logic mode_needs_post(input mode_e m);
      return (m == MODE_ODD);
   endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply: full-width product, arithmetic shift right by
// FRAC_BITS (floor), then clamp to the DATA_WIDTH signed range.
module fxp_mul_sat #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FRAC_BITS  = 16
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] product_c,
   output logic                  sat_c
);

   localparam int unsigned PW = 2 * DATA_WIDTH;
   localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] b_ext;
   logic signed [PW-1:0] full;
   logic signed [PW-1:0] shifted;
   logic                 fits;

   always_comb begin
      a_ext   = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a});
      b_ext   = $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
      full    = a_ext * b_ext;
      shifted = full >>> FRAC_BITS;
      // Result fits when every bit above the target sign bit matches it.
      fits    = (&shifted[PW-1:DATA_WIDTH-1]) || (~|shifted[PW-1:DATA_WIDTH-1]);
      sat_c   = ~fits;
      if (fits) begin
         product_c = shifted[DATA_WIDTH-1:0];
      end else if (full[PW-1]) begin
         product_c = SAT_MIN;
      end else begin
         product_c = SAT_MAX;
      end
   end

endmodule

// File: rtl/taylor_horner_eval.sv
// Polynomial / Taylor-series evaluator: Horner iteration over a writable
// coefficient table with one shared saturating multiplier.
module taylor_horner_eval
   import nla_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
   parameter int unsigned ADDR_LINES = DEF_ADDR_LINES
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  coeff_we,
   input  logic [ADDR_LINES-1:0] coeff_addr,
   input  logic [DATA_WIDTH-1:0] coeff_wdata,
   output logic                  coeff_ready,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] x_i,
   input  logic [ADDR_LINES-1:0] taylor_length,
   input  logic [1:0]            mode_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  sat_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_LINES;
   localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   state_e                state;
   state_e                state_n;
   mode_e                 mode_q;
   mode_e                 mode_n;
   logic [DATA_WIDTH-1:0] x_q;
   logic [DATA_WIDTH-1:0] x_n;
   logic [DATA_WIDTH-1:0] x_eff_q;
   logic [DATA_WIDTH-1:0] x_eff_n;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH-1:0] acc_n;
   logic [ADDR_LINES-1:0] k_q;
   logic [ADDR_LINES-1:0] k_n;
   logic [ADDR_LINES-1:0] len_q;
   logic [ADDR_LINES-1:0] len_n;
   logic                  sat_q;
   logic                  sat_n;

   logic [DATA_WIDTH-1:0] coeff_mem [DEPTH];
   logic [ADDR_LINES-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] coeff_rd;

   logic [DATA_WIDTH-1:0] mul_a;
   logic [DATA_WIDTH-1:0] mul_b;
   logic [DATA_WIDTH-1:0] mul_p;
   logic                  mul_sat;

   logic [DATA_WIDTH:0]   sum_w;
   logic [DATA_WIDTH-1:0] add_p;
   logic                  add_sat;

   // Coefficient table: no reset, writes only while the evaluator is idle.
   always_ff @(posedge clk_i) begin
      if (coeff_we && coeff_ready) begin
         coeff_mem[coeff_addr] <= coeff_wdata;
      end
   end

   // PREP fetches c[N]; ITER fetches c[k-1].
   always_comb begin
      rd_addr  = (state == S_PREP) ? len_q : (k_q - ADDR_LINES'(1));
      coeff_rd = coeff_mem[rd_addr];
   end

   // Shared multiplier operand select.
   always_comb begin
      mul_a = acc_q;
      mul_b = x_eff_q;
      case (state)
         S_PREP: begin
            mul_a = x_q;
            mul_b = x_q;
         end
         S_POST: begin
            mul_a = acc_q;
            mul_b = x_q;
         end
         default: begin
            mul_a = acc_q;
            mul_b = x_eff_q;
         end
      endcase
   end

   fxp_mul_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_mul (
      .a         (mul_a),
      .b         (mul_b),
      .product_c (mul_p),
      .sat_c     (mul_sat)
   );

   // Saturating add of the Horner product and the next coefficient.
   always_comb begin
      sum_w   = {mul_p[DATA_WIDTH-1], mul_p} + {coeff_rd[DATA_WIDTH-1], coeff_rd};
      add_sat = sum_w[DATA_WIDTH] ^ sum_w[DATA_WIDTH-1];
      if (!add_sat) begin
         add_p = sum_w[DATA_WIDTH-1:0];
      end else if (sum_w[DATA_WIDTH]) begin
         add_p = SAT_MIN;
      end else begin
         add_p = SAT_MAX;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_n = state;
      mode_n  = mode_q;
      x_n     = x_q;
      x_eff_n = x_eff_q;
      acc_n   = acc_q;
      k_n     = k_q;
      len_n   = len_q;
      sat_n   = sat_q;
      case (state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               x_n     = x_i;
               len_n   = taylor_length;
               mode_n  = mode_e'(mode_i);
               sat_n   = 1'b0;
               state_n = S_PREP;
            end
         end
         S_PREP: begin
            acc_n = coeff_rd;
            k_n   = len_q;
            if (mode_uses_square(mode_q)) begin
               x_eff_n = mul_p;
               sat_n   = sat_q | mul_sat;
            end else begin
               x_eff_n = x_q;
            end
            if (len_q != '0) begin
               state_n = S_ITER;
            end else if (mode_needs_post(mode_q)) begin
               state_n = S_POST;
            end else begin
               state_n = S_DONE;
            end
         end
         S_ITER: begin
            acc_n = add_p;
            sat_n = sat_q | mul_sat | add_sat;
            k_n   = k_q - ADDR_LINES'(1);
            if (k_q == ADDR_LINES'(1)) begin
               state_n = mode_needs_post(mode_q) ? S_POST : S_DONE;
            end
         end
         S_POST: begin
            acc_n   = mul_p;
            sat_n   = sat_q | mul_sat;
            state_n = S_DONE;
         end
         S_DONE: begin
            if (out_valid && out_ready) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         mode_q  <= MODE_ALL;
         x_q     <= '0;
         x_eff_q <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         len_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         mode_q  <= mode_n;
         x_q     <= x_n;
         x_eff_q <= x_eff_n;
         acc_q   <= acc_n;
         k_q     <= k_n;
         len_q   <= len_n;
         sat_q   <= sat_n;
      end
   end

   // Handshake and result outputs registered from the next-state decode.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         in_ready    <= 1'b1;
         coeff_ready <= 1'b1;
         out_valid   <= 1'b0;
         result      <= '0;
         sat_o       <= 1'b0;
      end else begin
         in_ready    <= (state_n == S_IDLE);
         coeff_ready <= (state_n == S_IDLE);
         out_valid   <= (state_n == S_DONE);
         if (state_n == S_DONE) begin
            result <= acc_n;
            sat_o  <= sat_n;
         end
      end
   end

endmodule

// File: tb/tb_taylor_horner_eval.sv
// Self-checking bench: directed scenarios plus randomized runs against a
// plain-arithmetic polynomial model.
module tb_taylor_horner_eval;

   localparam int unsigned DW = 32;
   localparam int unsigned FB = 16;
   localparam int unsigned AL = 5;
   localparam int unsigned DEPTH = 2 ** AL;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          coeff_we = 1'b0;
   logic [AL-1:0] coeff_addr = '0;
   logic [DW-1:0] coeff_wdata = '0;
   logic          coeff_ready;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] x_i = '0;
   logic [AL-1:0] taylor_length = '0;
   logic [1:0]    mode_i = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] result;
   logic          sat_o;

   int n_assert = 0;
   int n_fail   = 0;
   logic [DW-1:0] model_c [DEPTH];
   bit m_sat;

   taylor_horner_eval #(
      .DATA_WIDTH (DW),
      .FRAC_BITS  (FB),
      .ADDR_LINES (AL)
   ) dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .coeff_we      (coeff_we),
      .coeff_addr    (coeff_addr),
      .coeff_wdata   (coeff_wdata),
      .coeff_ready   (coeff_ready),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .x_i           (x_i),
      .taylor_length (taylor_length),
      .mode_i        (mode_i),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result        (result),
      .sat_o         (sat_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic on 64-bit integers: clamp, Q-format multiply, add.
   function automatic longint clampv(input longint v);
      if (v > MAXV) begin
         m_sat = 1'b1;
         return MAXV;
      end
      if (v < MINV) begin
         m_sat = 1'b1;
         return MINV;
      end
      return v;
   endfunction

   function automatic longint fmul(input longint a, input longint b);
      return clampv((a * b) >>> FB);
   endfunction

   function automatic void model_eval(input logic [DW-1:0] x, input int n, input int mode,
                                      output logic [DW-1:0] r, output bit s);
      longint xv;
      longint xe;
      longint acc;
      m_sat = 1'b0;
      xv  = longint'($signed(x));
      xe  = (mode == 1 || mode == 2) ? fmul(xv, xv) : xv;
      acc = longint'($signed(model_c[n]));
      for (int k = n; k > 0; k--) begin
         acc = clampv(fmul(acc, xe) + longint'($signed(model_c[k-1])));
      end
      if (mode == 2) begin
         acc = fmul(acc, xv);
      end
      r = acc[DW-1:0];
      s = m_sat;
   endfunction

   task automatic wr(input int a, input logic [DW-1:0] d);
      coeff_we    = 1'b1;
      coeff_addr  = AL'(a);
      coeff_wdata = d;
      @(posedge clk_i);
      #1;
      coeff_we = 1'b0;
      model_c[a] = d;
   endtask

   // One evaluation: accept, measure latency, hold in DONE for 'stall' cycles
   // (optionally trying a coefficient write), then handshake.
   task automatic run(input string tag, input logic [DW-1:0] x, input int n, input int mode,
                      input int stall, input bit drop_wr,
                      output logic [DW-1:0] got, output logic got_sat);
      logic [DW-1:0] er;
      bit es;
      int lat;
      int exp_lat;
      model_eval(x, n, mode, er, es);
      exp_lat = n + 2 + ((mode == 2) ? 1 : 0);
      x_i = x;
      taylor_length = AL'(n);
      mode_i = 2'(mode);
      in_valid = 1'b1;
      @(posedge clk_i);
      #1;
      lat = 1;
      // Busy-time input changes must be ignored.
      x_i = $urandom;
      taylor_length = AL'($urandom);
      mode_i = 2'($urandom);
      while (!out_valid && lat < 64) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_result"}, 64'(result), 64'(er));
      chk({tag, "_sat"}, 64'(sat_o), 64'(es));
      got = result;
      got_sat = sat_o;
      for (int s = 0; s < stall; s++) begin
         out_ready = 1'b0;
         if (s == 0 && drop_wr) begin
            coeff_we = 1'b1;
            coeff_addr = '0;
            coeff_wdata = ~model_c[0];
         end
         @(posedge clk_i);
         #1;
         coeff_we = 1'b0;
         chk({tag, "_stall_valid"}, 64'(out_valid), 64'(1));
         chk({tag, "_stall_result"}, 64'(result), 64'(er));
         chk({tag, "_stall_in_ready"}, 64'(in_ready), 64'(0));
         chk({tag, "_stall_coeff_ready"}, 64'(coeff_ready), 64'(0));
      end
      out_ready = 1'b1;
      @(posedge clk_i);
      #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk({tag, "_after_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_after_in_ready"}, 64'(in_ready), 64'(1));
   endtask

   function automatic logic [DW-1:0] rnd_val(input int span);
      if ($urandom_range(0, 9) == 0) begin
         return DW'($urandom);
      end
      return DW'(int'($urandom_range(0, 2 * span)) - span);
   endfunction

   initial begin
      logic [DW-1:0] g;
      logic gs;
      logic [DW-1:0] old_c0;
      int n;
      int mode;

      // Reset values.
      rstn_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_coeff_ready", 64'(coeff_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_sat", 64'(sat_o), 64'(0));
      rstn_i = 1'b1;

      for (int i = 0; i < int'(DEPTH); i++) wr(i, '0);

      // Basic ALL evaluation.
      wr(0, 32'h0001_0000);
      wr(1, 32'h0001_0000);
      wr(2, 32'h0000_8000);
      run("all_n2", 32'h0001_0000, 2, 0, 0, 1'b0, g, gs);
      chk("all_n2_const", 64'(g), 64'h0002_8000);
      chk("all_n2_const_sat", 64'(gs), 64'(0));

      // ODD and EVEN with x = 2.0.
      run("odd_n1", 32'h0002_0000, 1, 2, 0, 1'b0, g, gs);
      chk("odd_n1_const", 64'(g), 64'h000A_0000);
      run("even_n1", 32'h0002_0000, 1, 1, 0, 1'b0, g, gs);
      chk("even_n1_const", 64'(g), 64'h0005_0000);
      run("rsvd_n2", 32'h0001_0000, 2, 3, 0, 1'b0, g, gs);
      chk("rsvd_n2_const", 64'(g), 64'h0002_8000);

      // Saturation both directions.
      wr(0, 32'h7FFF_0000);
      run("sat_pos", 32'h0002_0000, 1, 0, 0, 1'b0, g, gs);
      chk("sat_pos_const", 64'(g), 64'h7FFF_FFFF);
      chk("sat_pos_flag", 64'(gs), 64'(1));
      wr(0, 32'h8001_0000);
      run("sat_neg", 32'hFFFE_0000, 1, 0, 0, 1'b0, g, gs);
      chk("sat_neg_const", 64'(g), 64'h8000_0000);
      chk("sat_neg_flag", 64'(gs), 64'(1));

      // Stall in DONE with a dropped coefficient write, then readback c[0].
      wr(0, 32'h0003_4000);
      old_c0 = model_c[0];
      run("stall", 32'h0000_C000, 2, 0, 5, 1'b1, g, gs);
      run("readback", 32'h1234_5678, 0, 0, 0, 1'b0, g, gs);
      chk("readback_const", 64'(g), 64'(old_c0));

      // Reset in the middle of ITER.
      for (int i = 0; i <= 10; i++) wr(i, 32'h0000_4000 + DW'(i));
      old_c0 = model_c[0];
      x_i = 32'h0001_8000;
      taylor_length = AL'(10);
      mode_i = 2'd0;
      in_valid = 1'b1;
      @(posedge clk_i);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rstn_i = 1'b0;
      @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_result", 64'(result), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      chk("midrst_sat", 64'(sat_o), 64'(0));
      run("post_rst", 32'h0002_0000, 0, 0, 0, 1'b0, g, gs);
      chk("post_rst_const", 64'(g), 64'(old_c0));

      // Randomized runs against the model.
      for (int t = 0; t < 40; t++) begin
         n = (t % 10 == 9) ? int'(DEPTH) - 1 : int'($urandom_range(0, 6));
         mode = int'($urandom_range(0, 3));
         for (int i = 0; i <= n; i++) wr(i, rnd_val(2 * 65536));
         run($sformatf("rand%0d", t), rnd_val(3 * 32768), n, mode,
             int'($urandom_range(0, 2)), 1'b0, g, gs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
